// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop line synchronizer, mid-bit start validation, LSB-first capture.
// Latency: strobe visible the cycle after the stop-bit sample edge, E(3+HALF_BIT+9*CYCLE_PER_BIT).
// No backpressure: byte_rx is held until the next good frame, strobes are single-cycle.
module uart_rx #(
  parameter int CYCLE_PER_BIT = 115,
  parameter int HALF_BIT      = (CYCLE_PER_BIT - 1) / 2
) (
  input  logic       clk_rx,
  input  logic       rst_rx,
  input  logic       serial_rx,
  output logic [7:0] byte_rx,
  output logic       out_valid_rx,
  output logic       out_frame_err_rx,
  output logic       out_busy_rx
);

  localparam logic [7:0] LAST_CNT = 8'(CYCLE_PER_BIT - 1);
  localparam logic [7:0] HALF_CNT = 8'(HALF_BIT);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_BIT = 3'd1,
    DATA_BIT  = 3'd2,
    STOP_BIT  = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t     state;
  logic       sync1;
  logic       sync2;
  logic [7:0] cnt;
  logic [2:0] idx;
  logic [7:0] shreg;

  // Bring the asynchronous line into the clock domain; reset to the idle (high) level.
  always_ff @(posedge clk_rx or negedge rst_rx) begin
    if (!rst_rx) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= serial_rx;
      sync2 <= sync1;
    end
  end

  // Receive FSM with registered strobes and busy flag.
  always_ff @(posedge clk_rx or negedge rst_rx) begin
    if (!rst_rx) begin
      state            <= IDLE;
      cnt              <= 8'd0;
      idx              <= 3'd0;
      shreg            <= 8'h00;
      byte_rx          <= 8'h00;
      out_valid_rx     <= 1'b0;
      out_frame_err_rx <= 1'b0;
      out_busy_rx      <= 1'b0;
    end else begin
      out_valid_rx     <= 1'b0;
      out_frame_err_rx <= 1'b0;
      case (state)
        IDLE: begin
          if (!sync2) begin
            state       <= START_BIT;
            cnt         <= 8'd0;
            out_busy_rx <= 1'b1;
          end
        end
        START_BIT: begin
          if (cnt == HALF_CNT) begin
            cnt <= 8'd0;
            if (!sync2) begin
              state <= DATA_BIT;
              idx   <= 3'd0;
            end else begin
              // Line went back high before mid-bit: treat as a glitch.
              state       <= IDLE;
              out_busy_rx <= 1'b0;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DATA_BIT: begin
          if (cnt == LAST_CNT) begin
            cnt        <= 8'd0;
            shreg[idx] <= sync2;
            if (idx == 3'd7) begin
              state <= STOP_BIT;
            end else begin
              idx <= idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        STOP_BIT: begin
          if (cnt == LAST_CNT) begin
            cnt <= 8'd0;
            if (sync2) begin
              byte_rx      <= shreg;
              out_valid_rx <= 1'b1;
              state        <= IDLE;
              out_busy_rx  <= 1'b0;
            end else begin
              out_frame_err_rx <= 1'b1;
              state            <= WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        WAIT_IDLE: begin
          // A held-low break stays here so it reports only one error.
          if (sync2) begin
            state       <= IDLE;
            cnt         <= 8'd0;
            out_busy_rx <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          cnt         <= 8'd0;
          out_busy_rx <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames driven bit by bit, strobes and busy edges time-stamped.
// Expected bytes and edge offsets are hand-computed from the frame timing.
// Every wait is a fixed number of clocks, so the run always ends.
module tb_uart_rx;

  localparam int CPB = 115;

  logic       clk;
  logic       rst_n;
  logic       serial;
  logic [7:0] byte_rx;
  logic       out_valid_rx;
  logic       out_frame_err_rx;
  logic       out_busy_rx;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int e0 = 0;
  int e0_first = 0;
  int vq[$];
  logic [7:0] bq[$];
  int err_cnt = 0;
  int both_cnt = 0;
  int rise_cyc = -1;
  int fall_cyc = -1;
  logic busy_q = 1'b0;
  int n_valid_before;
  int n_err_before;

  uart_rx #(.CYCLE_PER_BIT(CPB)) dut (
    .clk_rx           (clk),
    .rst_rx           (rst_n),
    .serial_rx        (serial),
    .byte_rx          (byte_rx),
    .out_valid_rx     (out_valid_rx),
    .out_frame_err_rx (out_frame_err_rx),
    .out_busy_rx      (out_busy_rx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Time-stamp strobes and busy edges away from the active edge.
  always @(negedge clk) begin
    if (out_valid_rx) begin
      vq.push_back(cyc);
      bq.push_back(byte_rx);
    end
    if (out_frame_err_rx) err_cnt++;
    if (out_valid_rx && out_frame_err_rx) both_cnt++;
    if (out_busy_rx && !busy_q) rise_cyc = cyc;
    if (!out_busy_rx && busy_q) fall_cyc = cyc;
    busy_q = out_busy_rx;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called on a negedge; returns on a negedge right after the stop bit period.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    e0 = cyc + 1;
    serial = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      serial = d[i];
      idle(CPB);
    end
    serial = stop_bit;
    idle(CPB);
  endtask

  task automatic send_good(input string tag, input logic [7:0] d);
    n_valid_before = vq.size();
    send_frame(d, 1'b1);
    idle(10);
    check({tag, "_nvalid"}, vq.size(), n_valid_before + 1);
    check({tag, "_byte"}, byte_rx, d);
    if (vq.size() == n_valid_before + 1)
      check({tag, "_vtime"}, vq[n_valid_before] - e0, 1095);
  endtask

  initial begin
    serial = 1'b1;
    rst_n  = 1'b0;
    idle(3);
    check("rst_byte", byte_rx, 8'h00);
    check("rst_valid", out_valid_rx, 1'b0);
    check("rst_err", out_frame_err_rx, 1'b0);
    check("rst_busy", out_busy_rx, 1'b0);
    rst_n = 1'b1;
    idle(10);

    // Basic frame, busy window and strobe width
    send_good("a5", 8'hA5);
    check("a5_busy_rise", rise_cyc - e0, 2);
    check("a5_busy_fall", fall_cyc - e0, 1095);
    check("a5_strobe_byte", bq[0], 8'hA5);
    check("a5_busy_after", out_busy_rx, 1'b0);

    // Back-to-back 0x00 then 0xFF, no idle gap
    n_valid_before = vq.size();
    n_err_before   = err_cnt;
    send_frame(8'h00, 1'b1);
    e0_first = e0;
    send_frame(8'hFF, 1'b1);
    idle(10);
    check("b2b_nvalid", vq.size(), n_valid_before + 2);
    if (vq.size() == n_valid_before + 2) begin
      check("b2b_t0", vq[n_valid_before] - e0_first, 1095);
      check("b2b_gap", vq[n_valid_before + 1] - vq[n_valid_before], 1150);
      check("b2b_byte0", bq[n_valid_before], 8'h00);
      check("b2b_byte1", bq[n_valid_before + 1], 8'hFF);
    end
    check("b2b_noerr", err_cnt, n_err_before);
    check("b2b_byte_hold", byte_rx, 8'hFF);

    // Short low pulse rejected at start-bit mid-sample
    n_valid_before = vq.size();
    e0 = cyc + 1;
    serial = 1'b0;
    idle(20);
    serial = 1'b1;
    idle(80);
    check("glitch_rise", rise_cyc - e0, 2);
    check("glitch_fall", fall_cyc - e0, 60);
    check("glitch_nvalid", vq.size(), n_valid_before);
    check("glitch_noerr", err_cnt, n_err_before);
    check("glitch_byte", byte_rx, 8'hFF);

    // Framing error followed by a long break, then a good frame
    n_valid_before = vq.size();
    send_frame(8'h3C, 1'b0);
    idle(3000);
    check("brk_busy", out_busy_rx, 1'b1);
    serial = 1'b1;
    idle(20);
    check("brk_errs", err_cnt, n_err_before + 1);
    check("brk_nvalid", vq.size(), n_valid_before);
    check("brk_byte", byte_rx, 8'hFF);
    check("brk_idle", out_busy_rx, 1'b0);
    send_good("5a", 8'h5A);

    // Reset in the middle of data bit 4 of 0x81
    n_valid_before = vq.size();
    serial = 1'b0;
    idle(CPB);
    for (int i = 0; i < 4; i++) begin
      serial = (i == 0) ? 1'b1 : 1'b0;
      idle(CPB);
    end
    serial = 1'b0;
    idle(50);
    check("mid_busy", out_busy_rx, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_byte", byte_rx, 8'h00);
    check("mid_rst_valid", out_valid_rx, 1'b0);
    check("mid_rst_err", out_frame_err_rx, 1'b0);
    check("mid_rst_busy", out_busy_rx, 1'b0);
    serial = 1'b1;
    idle(5);
    rst_n = 1'b1;
    idle(CPB * 6);
    check("mid_nvalid", vq.size(), n_valid_before);
    send_good("81", 8'h81);

    // Bit ordering
    send_good("01", 8'h01);
    send_good("80", 8'h80);

    check("final_errs", err_cnt, n_err_before + 1);
    check("never_both", both_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver; the receive-side counterpart to the design's UART transmitter.
- Oversamples the asynchronous serial line on the system clock, validates the start bit at mid-bit, and samples 8 data bits LSB first plus one stop bit.
- Presents each received byte with a one-cycle valid strobe.
- Flags stop-bit (framing) errors and stalls until the line returns to idle.

Parameters:
- CYCLE_PER_BIT, 115, clocks per bit period; legal range 4..256 (8-bit counter).
- HALF_BIT, (CYCLE_PER_BIT-1)/2 = 57, clocks from detected start edge to start-bit mid-sample.

Ports:
- clk_rx  in  1  system clock; all state is on its rising edge.
- rst_rx  in  1  reset; asynchronous, active-low.
- serial_rx  in  1  asynchronous serial line; idles high.
- byte_rx  out  8  last correctly received byte; held until the next good frame.
- out_valid_rx  out  1  one-cycle pulse when byte_rx is updated.
- out_frame_err_rx  out  1  one-cycle pulse when the stop bit samples 0.
- out_busy_rx  out  1  high in every state other than IDLE.

Behaviour:
- Reset (rst_rx low, asynchronous):
  - Both synchronizer flops are forced to 1.
  - State = IDLE, bit counter = 0, bit index = 0, shift register = 0x00.
  - byte_rx = 0x00; out_valid_rx, out_frame_err_rx and out_busy_rx = 0.
  - Reset mid-frame abandons the frame; no strobe is issued for it.
- Synchronizer: 2 flops; sync2 is the only line value seen by the FSM. No other logic reads serial_rx.
- Bit counter: 8 bits, cleared on every state change.
- IDLE:
  - sync2 == 0 -> START_BIT, counter = 0.
  - Otherwise stay in IDLE.
- START_BIT:
  - Counter increments each clock.
  - At counter == HALF_BIT: if sync2 == 0 -> DATA_BIT with counter = 0 and index = 0; else -> IDLE (glitch rejected, no strobe).
- DATA_BIT:
  - Counter increments each clock.
  - At counter == CYCLE_PER_BIT-1: shift sync2 into bit [index] (LSB first) and clear the counter.
  - If index == 7 -> STOP_BIT; else index + 1.
- STOP_BIT:
  - At counter == CYCLE_PER_BIT-1, sample sync2.
  - If 1: byte_rx <= shift register, out_valid_rx pulses for 1 cycle, -> IDLE.
  - If 0: out_frame_err_rx pulses for 1 cycle, byte_rx unchanged, -> WAIT_IDLE.
- WAIT_IDLE: stay until sync2 == 1, then -> IDLE. A held-low break therefore yields exactly one error pulse.
- Timing:
  - Let E0 be the first clock edge that samples serial_rx low.
  - IDLE leaves at E2.
  - Data bit i is sampled at E(3+HALF_BIT+(i+1)*CYCLE_PER_BIT).
  - The stop bit is sampled at E(3+HALF_BIT+9*CYCLE_PER_BIT).
  - The strobe is visible in the cycle after that edge. With defaults this is E1095.
- Back-to-back frames: returning to IDLE at stop-bit mid-sample leaves about half a bit of margin. The next start edge is detected without loss.
- out_valid_rx and out_frame_err_rx are never high in the same cycle.
- State encoding: 3 bits. Unused codes -> IDLE.

Test Plan:
- Reset high, line idle, then send frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop) at CYCLE_PER_BIT=115 -> out_valid_rx high for exactly 1 cycle after E1095; byte_rx = 0xA5; out_busy_rx high from E2 until return to IDLE.
- Send 0x00 then 0xFF back-to-back with no idle gap -> two valid pulses exactly 10*115 clocks apart; byte_rx = 0x00, then 0xFF; no error pulse.
- Drive line low for 20 clocks, then high -> returns to IDLE at E(3+57); no valid pulse, no error pulse; byte_rx keeps its prior value.
- Frame 0x3C with stop bit driven 0, line held low for 3000 clocks, then high -> one out_frame_err_rx pulse; byte_rx keeps the old value; a following good frame 0x5A is received correctly.
- Assert rst_rx low during DATA_BIT bit 4 of frame 0x81 -> all outputs 0 immediately; no strobe for that frame; a following frame 0x81 yields byte_rx = 0x81.
- Frame 0x01 -> byte_rx = 0x01, confirming LSB-first ordering; frame 0x80 -> byte_rx = 0x80.
